// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run/verdict controller for an RV32IM core
//
// Purpose: sequences the CPU reset, then watches the core's PC and store bus.
// It reaches a sticky verdict in one of four ways: a tohost store gives pass
// or fail, a self-looping PC gives halt, and a cycle budget gives timeout.
//
// Ports:
//   CLK        in   rising-edge clock
//   RST        in   synchronous active-high reset (dominates every state)
//   PC         in   CPU program counter
//   ALUResult  in   CPU ALU result, used as the store address
//   WriteData  in   CPU store data
//   MemWrite   in   CPU store strobe
//   CPU_RST    out  reset to the CPU core (held in RESET and terminal states)
//   Status     out  0 RESET, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 HALT
//   Done       out  high in any terminal state
//   Pass       out  high only in PASS
//   FailCode   out  failing test number (tohost value >> 1)
//   CycleCount out  cycles spent in RUN
//   StoreCount out  MemWrite cycles seen in RUN, saturating

module cpu_run_controller #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     CNT_W        = 32,
  parameter int unsigned     RESET_CYCLES = 2,
  parameter int unsigned     MAX_CYCLES   = 500,
  parameter logic [XLEN-1:0] TOHOST_ADDR  = XLEN'(32'h0000_00FC),
  parameter int unsigned     LOOP_LIMIT   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  ALUResult,
  input  logic [XLEN-1:0]  WriteData,
  input  logic             MemWrite,
  output logic             CPU_RST,
  output logic [2:0]       Status,
  output logic             Done,
  output logic             Pass,
  output logic [XLEN-1:0]  FailCode,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] StoreCount
);

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  // A zero-cycle reset hold would let the core run straight out of RST.
  localparam int unsigned HOLD = (RESET_CYCLES == 0) ? 1 : RESET_CYCLES;

  state_t            state;
  logic [CNT_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]  same_cnt;
  logic [XLEN-1:0]   prev_pc;

  logic [CNT_W-1:0]  cycle_next;
  logic [CNT_W-1:0]  store_next;
  logic [CNT_W-1:0]  same_next;
  logic              first_run;
  logic              pc_match;
  logic              tohost;
  logic              halt_hit;
  logic              timeout_hit;

  assign Status = state;

  always_comb begin
    cycle_next  = CycleCount + CNT_W'(1);
    store_next  = (StoreCount == '1) ? StoreCount : StoreCount + CNT_W'(1);
    // CycleCount is still zero only on the first RUN cycle, where prev_pc
    // holds its reset value rather than a real PC.
    first_run   = (CycleCount == '0);
    pc_match    = !first_run && (PC == prev_pc);
    same_next   = pc_match ? same_cnt + CNT_W'(1) : '0;
    tohost      = MemWrite && (ALUResult == TOHOST_ADDR) && WriteData[0];
    halt_hit    = (same_next == CNT_W'(LOOP_LIMIT));
    timeout_hit = (cycle_next == CNT_W'(MAX_CYCLES));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_RESET;
      CPU_RST    <= 1'b1;
      Done       <= 1'b0;
      Pass       <= 1'b0;
      FailCode   <= '0;
      CycleCount <= '0;
      StoreCount <= '0;
      hold_cnt   <= '0;
      same_cnt   <= '0;
      prev_pc    <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          CPU_RST  <= 1'b1;
          hold_cnt <= hold_cnt + CNT_W'(1);
          if (hold_cnt + CNT_W'(1) >= CNT_W'(HOLD)) begin
            state   <= ST_RUN;
            CPU_RST <= 1'b0;
          end
        end

        ST_RUN: begin
          CycleCount <= cycle_next;
          prev_pc    <= PC;
          same_cnt   <= same_next;
          if (MemWrite) begin
            StoreCount <= store_next;
          end

          // Verdict priority: tohost, then self-loop halt, then timeout.
          if (tohost) begin
            CPU_RST <= 1'b1;
            Done    <= 1'b1;
            if (WriteData == XLEN'(1)) begin
              state <= ST_PASS;
              Pass  <= 1'b1;
            end else begin
              state    <= ST_FAIL;
              FailCode <= {1'b0, WriteData[XLEN-1:1]};
            end
          end else if (halt_hit) begin
            state   <= ST_HALT;
            CPU_RST <= 1'b1;
            Done    <= 1'b1;
          end else if (timeout_hit) begin
            state   <= ST_TIMEOUT;
            CPU_RST <= 1'b1;
            Done    <= 1'b1;
          end
        end

        // Terminal states are sticky: every register holds until RST.
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - testbench for cpu_run_controller

module tb_cpu_run_controller;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        CPU_RST;
  logic [2:0]  Status;
  logic        Done;
  logic        Pass;
  logic [31:0] FailCode;
  logic [31:0] CycleCount;
  logic [31:0] StoreCount;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  cpu_run_controller dut (
    .CLK        (CLK),
    .RST        (RST),
    .PC         (PC),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .MemWrite   (MemWrite),
    .CPU_RST    (CPU_RST),
    .Status     (Status),
    .Done       (Done),
    .Pass       (Pass),
    .FailCode   (FailCode),
    .CycleCount (CycleCount),
    .StoreCount (StoreCount)
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wd;
    logic        mw;
    logic [2:0]  st;
    logic        cr;
    logic        dn;
    logic        ps;
    logic [31:0] cyc;
    logic [31:0] sc;
    logic [31:0] fc;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] TH = 32'h0000_00FC;

  task automatic add(input logic rst, input logic [31:0] pc, input logic [31:0] alu,
                     input logic [31:0] wd, input logic mw, input logic [2:0] st,
                     input logic cr, input logic dn, input logic ps,
                     input logic [31:0] cyc, input logic [31:0] sc, input logic [31:0] fc);
    vec_t v;
    v.rst = rst; v.pc = pc; v.alu = alu; v.wd = wd; v.mw = mw;
    v.st = st; v.cr = cr; v.dn = dn; v.ps = ps; v.cyc = cyc; v.sc = sc; v.fc = fc;
    vecs.push_back(v);
  endtask

  // RST for one cycle, then two hold cycles; RUN begins after the second.
  task automatic add_reset();
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // Plain RUN cycle with no store.
  task automatic add_run(input logic [31:0] pc, input logic [31:0] cyc, input logic [31:0] sc);
    add(0, pc, 0, 0, 0, 1, 0, 0, 0, cyc, sc, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] pc, input logic [31:0] alu,
                      input logic [31:0] wd, input logic mw);
    RST = rst; PC = pc; ALUResult = alu; WriteData = wd; MemWrite = mw;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("reset_to_run status", 32'(Status), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset sequencing, then a pass on the 11th RUN cycle, then hold.
    add_reset();
    for (int n = 1; n <= 10; n++) add_run(32'(n * 4), 32'(n), 0);
    add(0, 44, TH, 1, 1, 2, 1, 1, 1, 11, 1, 0);
    for (int k = 0; k < 20; k++) add(0, 32'h40, TH, 7, 1, 2, 1, 1, 1, 11, 1, 0);

    // Mid-run reset clears counters, a re-run passes, reset in PASS, re-run again.
    add_reset();
    add_run(4, 1, 0);
    add(0, 8, 32'h100, 3, 1, 1, 0, 0, 0, 2, 1, 0);
    add_reset();
    add_run(4, 1, 0);
    add_run(8, 2, 0);
    add(0, 12, TH, 1, 1, 2, 1, 1, 1, 3, 1, 0);
    add_reset();
    add_run(4, 1, 0);
    add_run(8, 2, 0);
    add(0, 12, TH, 1, 1, 2, 1, 1, 1, 3, 1, 0);

    // Fail with code 3, sticky.
    add_reset();
    for (int n = 1; n <= 3; n++) add_run(32'(n * 4), 32'(n), 0);
    add(0, 16, TH, 7, 1, 3, 1, 1, 0, 4, 1, 3);
    add(0, 20, TH, 1, 1, 3, 1, 1, 0, 4, 1, 3);
    add(0, 24, TH, 1, 1, 3, 1, 1, 0, 4, 1, 3);

    // Fail on the first RUN cycle with all-ones data.
    add_reset();
    add(0, 4, TH, 32'hFFFF_FFFF, 1, 3, 1, 1, 0, 1, 1, 32'h7FFF_FFFF);

    // Non-verdict stores: wrong address, even data, address differing in bit 31.
    add_reset();
    add_run(4, 1, 0);
    add(0, 8, 32'h100, 7, 1, 1, 0, 0, 0, 2, 1, 0);
    add(0, 12, TH, 4, 1, 1, 0, 0, 0, 3, 2, 0);
    add(0, 16, 32'h8000_00FC, 1, 1, 1, 0, 0, 0, 4, 3, 0);
    add_run(20, 5, 3);

    // PC at 0 from the first RUN cycle: first cycle must not match prev_pc reset value.
    add_reset();
    for (int n = 1; n <= 4; n++) add_run(0, 32'(n), 0);
    add(0, 0, 0, 0, 0, 5, 1, 1, 0, 5, 0, 0);
    add(0, 4, TH, 1, 1, 5, 1, 1, 0, 5, 0, 0);

    // Same-PC run broken by a PC change, then five equal PCs halt.
    add_reset();
    add_run(32'h3C, 1, 0);
    add_run(32'h40, 2, 0);
    add_run(32'h40, 3, 0);
    add_run(32'h40, 4, 0);
    for (int n = 5; n <= 8; n++) add_run(32'h44, 32'(n), 0);
    add(0, 32'h44, 0, 0, 0, 5, 1, 1, 0, 9, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].pc, vecs[i].alu, vecs[i].wd, vecs[i].mw);
      chk($sformatf("v%0d Status", i),     32'(Status),  32'(vecs[i].st));
      chk($sformatf("v%0d CPU_RST", i),    32'(CPU_RST), 32'(vecs[i].cr));
      chk($sformatf("v%0d Done", i),       32'(Done),    32'(vecs[i].dn));
      chk($sformatf("v%0d Pass", i),       32'(Pass),    32'(vecs[i].ps));
      chk($sformatf("v%0d CycleCount", i), CycleCount,   vecs[i].cyc);
      chk($sformatf("v%0d StoreCount", i), StoreCount,   vecs[i].sc);
      chk($sformatf("v%0d FailCode", i),   FailCode,     vecs[i].fc);
    end

    // Timeout at exactly 500 RUN cycles.
    do_reset();
    for (int n = 1; n <= 499; n++) step(0, 32'(n * 4), 0, 0, 0);
    chk("timeout pre status", 32'(Status), 1);
    chk("timeout pre cycles", CycleCount, 499);
    step(0, 32'd2000, 0, 0, 0);
    chk("timeout status", 32'(Status), 4);
    chk("timeout cycles", CycleCount, 500);
    chk("timeout done", 32'(Done), 1);
    chk("timeout pass", 32'(Pass), 0);
    chk("timeout cpu_rst", 32'(CPU_RST), 1);
    step(0, 32'd2004, TH, 1, 1);
    chk("timeout sticky", 32'(Status), 4);
    chk("timeout frozen stores", StoreCount, 0);

    // Tohost pass beats 4th PC match and cycle 500 in the same cycle.
    do_reset();
    for (int n = 1; n <= 495; n++) step(0, 32'(n * 4), 0, 0, 0);
    for (int n = 496; n <= 499; n++) step(0, 32'h40, 0, 0, 0);
    chk("prio pass pre status", 32'(Status), 1);
    step(0, 32'h40, TH, 1, 1);
    chk("prio pass status", 32'(Status), 2);
    chk("prio pass cycles", CycleCount, 500);
    chk("prio pass pass", 32'(Pass), 1);
    chk("prio pass stores", StoreCount, 1);

    // Halt beats timeout in the same cycle.
    do_reset();
    for (int n = 1; n <= 495; n++) step(0, 32'(n * 4), 0, 0, 0);
    for (int n = 496; n <= 500; n++) step(0, 32'h40, 0, 0, 0);
    chk("prio halt status", 32'(Status), 5);
    chk("prio halt cycles", CycleCount, 500);
    chk("prio halt pass", 32'(Pass), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
